// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg -- shared definitions for the IR line-sensor error generator.
//
// Contents:
//   ir_state_e     sequencer states (IDLE, SETTLE, STRT, WAIT, DONE)
//   NUM_SENSORS    number of IR sensors sampled per frame
//   SAT_POS/NEG    16-bit signed saturation results
//   S16_MAX/MIN    18-bit signed limits used by the saturator
//   w_shift()      weight magnitude as a shift amount, per sensor index
//   w_neg()        weight sign, taken from index bit 2 (left half negative)
//   weighted_term  signed w[idx]*res built with a shift and conditional negate
// ---------------------------------------------------------------------------
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    STRT   = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } ir_state_e;

  localparam int NUM_SENSORS = 8;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  localparam logic signed [17:0] S16_MAX = 18'sd32767;
  localparam logic signed [17:0] S16_MIN = -18'sd32768;

  // Weight magnitudes 8,4,2,1,1,2,4,8 expressed as shift amounts 3,2,1,0,0,1,2,3.
  function automatic logic [1:0] w_shift(input logic [2:0] idx);
    logic [1:0] sh;
    case (idx)
      3'd0:    sh = 2'd3;
      3'd1:    sh = 2'd2;
      3'd2:    sh = 2'd1;
      3'd3:    sh = 2'd0;
      3'd4:    sh = 2'd0;
      3'd5:    sh = 2'd1;
      3'd6:    sh = 2'd2;
      default: sh = 2'd3;
    endcase
    return sh;
  endfunction

  // Sensors 0..3 sit left of centre and pull the error negative.
  function automatic logic w_neg(input logic [2:0] idx);
    return ~idx[2];
  endfunction

  // Largest magnitude is 4095 << 3 = 32760, which fits in 15 bits.
  function automatic logic signed [17:0] weighted_term(input logic [2:0]  idx,
                                                       input logic [11:0] res);
    logic [14:0]        mag;
    logic signed [17:0] term;
    mag  = {3'b000, res} << w_shift(idx);
    term = $signed({3'b000, mag});
    return w_neg(idx) ? -term : term;
  endfunction

endpackage

// File: rtl/sat_s18_to_s16.sv
// ---------------------------------------------------------------------------
// sat_s18_to_s16 -- combinational signed saturator, 18-bit in, 16-bit out.
//
// Ports:
//   din   in  18  signed value
//   dout  out 16  din clamped to [-32768, 32767], two's complement
// ---------------------------------------------------------------------------
module sat_s18_to_s16
  import ir_pkg::*;
(
  input  logic signed [17:0] din,
  output logic        [15:0] dout
);

  always_comb begin
    dout = din[15:0];
    if (din > S16_MAX) begin
      dout = SAT_POS;
    end else if (din < S16_MIN) begin
      dout = SAT_NEG;
    end
  end

endmodule

// File: rtl/ir_err_gen.sv
// ---------------------------------------------------------------------------
// ir_err_gen -- sequences the 8 IR line sensors through the A2D converter and
// produces a saturated, signed, weighted left/right error for the PID block.
//
// Each frame: enable emitters, wait SETTLE_CYC cycles, then convert channels
// 0..7 back to back, accumulating w[idx]*res. At the end of a full frame the
// saturated error and a line-present flag are published with err_vld.
//
// Handshakes:
//   A2D side : strt_cnv is a one-cycle request while chnnl selects the
//              channel; the converter answers with a one-cycle cnv_cmplt and
//              res valid in that same cycle. Only one conversion is ever in
//              flight, and it is always allowed to finish.
//   PID side : err_vld is a one-cycle strobe in the cycle error and
//              line_present take their new values; both hold otherwise.
//
// Ports:
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous reset, active-low
//   go            in   1  frames run only while high
//   cnv_cmplt     in   1  A2D conversion complete pulse
//   res           in  12  A2D result for the current channel
//   strt_cnv      out  1  conversion request
//   chnnl         out  3  channel select, 0 = leftmost sensor
//   IR_en         out  1  IR emitter enable (registered)
//   error         out 16  signed weighted error, + means line right of centre
//   err_vld       out  1  error/line_present update strobe
//   line_present  out  1  any sensor >= LINE_THRESH during last full frame
// ---------------------------------------------------------------------------
module ir_err_gen
  import ir_pkg::*;
#(
  parameter int          SETTLE_CYC  = 4096,
  parameter logic [11:0] LINE_THRESH = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic        IR_en,
  output logic [15:0] error,
  output logic        err_vld,
  output logic        line_present
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  ir_state_e          state;
  logic [2:0]         idx;
  logic [CNT_W-1:0]   settle_cnt;
  logic signed [17:0] accum;
  logic signed [17:0] accum_upd;
  logic               seen;
  logic [15:0]        sat_out;

  // Worst-case |accum| is 15*4095 = 61425, well inside 18 bits signed.
  assign accum_upd = accum + weighted_term(idx, res);

  sat_s18_to_s16 u_sat (
    .din  (accum),
    .dout (sat_out)
  );

  // Request is gated by go so dropping go in STRT issues nothing.
  assign strt_cnv = (state == STRT) && go;
  assign chnnl    = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 3'd0;
      settle_cnt   <= '0;
      accum        <= '0;
      seen         <= 1'b0;
      IR_en        <= 1'b0;
      error        <= 16'h0000;
      err_vld      <= 1'b0;
      line_present <= 1'b0;
    end else begin
      err_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            accum      <= '0;
            seen       <= 1'b0;
            idx        <= 3'd0;
            settle_cnt <= '0;
            IR_en      <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (!go) begin
            IR_en <= 1'b0;
            state <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= STRT;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        STRT: begin
          if (!go) begin
            IR_en <= 1'b0;
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          // go is only honoured once the in-flight conversion has landed.
          if (cnv_cmplt) begin
            accum <= accum_upd;
            seen  <= seen | (res >= LINE_THRESH);
            if (!go) begin
              IR_en <= 1'b0;
              state <= IDLE;
            end else if (idx == 3'd7) begin
              IR_en <= 1'b0;
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= STRT;
            end
          end
        end

        DONE: begin
          error        <= sat_out;
          line_present <= seen;
          err_vld      <= 1'b1;
          if (go) begin
            accum      <= '0;
            seen       <= 1'b0;
            idx        <= 3'd0;
            settle_cnt <= '0;
            IR_en      <= 1'b1;
            state      <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          IR_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
